// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, fetches instruction words over a req/ready handshake
// and fills the F-side of the F/D pipeline register, dropping fetches made stale by redirects.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        eretD,
    input  logic [31:0] epc,
    input  logic        exc_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [31:0] PCplus4F,
    output logic        fetch_validF,
    output logic        adelF,
    output logic        fetch_stallF
);

    typedef enum logic {
        S_REQ     = 1'b0,
        S_DISCARD = 1'b1
    } state_t;

    state_t      state_r, state_n;
    logic [31:0] pc_r, pc_n;
    logic [31:0] tgt_r, tgt_n;
    logic [31:0] instr_r, instr_n;
    logic [31:0] pc4_r, pc4_n;
    logic        valid_r, valid_n;
    logic        adel_r, adel_n;

    logic        redir_s;
    logic [31:0] redir_tgt_s;
    logic        req_s;
    logic [31:0] pc_plus4_s;
    logic        misaligned_s;

    // Redirect source select, request generation and next-state computation
    always_comb begin
        state_n    = state_r;
        pc_n       = pc_r;
        tgt_n      = tgt_r;
        instr_n    = instr_r;
        pc4_n      = pc4_r;
        valid_n    = valid_r;
        adel_n     = adel_r;

        pc_plus4_s   = pc_r + 32'd4;
        misaligned_s = (pc_r[1:0] != 2'b00);

        if (exc_en) begin
            redir_s     = 1'b1;
            redir_tgt_s = EXC_VECTOR;
        end else if (eretD) begin
            redir_s     = 1'b1;
            redir_tgt_s = epc;
        end else if (redirect_en) begin
            redir_s     = 1'b1;
            redir_tgt_s = redirect_pc;
        end else begin
            redir_s     = 1'b0;
            redir_tgt_s = 32'h0000_0000;
        end

        // Request is withheld during reset so a mid-handshake reset drops it at once
        if (reset) begin
            req_s = 1'b0;
        end else if (state_r == S_DISCARD) begin
            req_s = 1'b1;
        end else begin
            req_s = !valid_r || enable;
        end

        case (state_r)
            S_REQ: begin
                if (redir_s) begin
                    valid_n = 1'b0;
                    if (req_s && !imem_ready) begin
                        // Keep pc (and so imem_addr) stable until the stale word returns
                        tgt_n   = redir_tgt_s;
                        state_n = S_DISCARD;
                    end else begin
                        pc_n = redir_tgt_s;
                    end
                end else if (req_s && imem_ready) begin
                    instr_n = misaligned_s ? 32'h0000_0000 : imem_rdata;
                    pc4_n   = pc_plus4_s;
                    adel_n  = misaligned_s;
                    valid_n = 1'b1;
                    pc_n    = pc_plus4_s;
                end else if (valid_r && enable) begin
                    valid_n = 1'b0;
                end else begin
                    valid_n = valid_r;
                end
            end
            S_DISCARD: begin
                if (imem_ready) begin
                    pc_n    = redir_s ? redir_tgt_s : tgt_r;
                    state_n = S_REQ;
                end else if (redir_s) begin
                    tgt_n = redir_tgt_s;
                end else begin
                    tgt_n = tgt_r;
                end
            end
            default: begin
                state_n = S_REQ;
                valid_n = 1'b0;
            end
        endcase
    end

    // State and F-side pipeline registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_REQ;
            pc_r    <= RESET_PC;
            tgt_r   <= 32'h0000_0000;
            instr_r <= 32'h0000_0000;
            pc4_r   <= 32'h0000_0000;
            valid_r <= 1'b0;
            adel_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            pc_r    <= pc_n;
            tgt_r   <= tgt_n;
            instr_r <= instr_n;
            pc4_r   <= pc4_n;
            valid_r <= valid_n;
            adel_r  <= adel_n;
        end
    end

    assign imem_req     = req_s;
    assign imem_addr    = {pc_r[31:2], 2'b00};
    assign InstrF       = instr_r;
    assign PCplus4F     = pc4_r;
    assign fetch_validF = valid_r;
    assign adelF        = adel_r;
    assign fetch_stallF = ~valid_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a cycle table of inputs and hand-computed
// expected outputs, plus a hand-written asynchronous reset sequence.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        eretD;
    logic [31:0] epc;
    logic        exc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] InstrF;
    logic [31:0] PCplus4F;
    logic        fetch_validF;
    logic        adelF;
    logic        fetch_stallF;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .eretD        (eretD),
        .epc          (epc),
        .exc_en       (exc_en),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .InstrF       (InstrF),
        .PCplus4F     (PCplus4F),
        .fetch_validF (fetch_validF),
        .adelF        (adelF),
        .fetch_stallF (fetch_stallF)
    );

    typedef struct {
        logic        en;
        logic        rdy;
        logic [31:0] rd;
        logic        ren;
        logic [31:0] rpc;
        logic        er;
        logic [31:0] ep;
        logic        ex;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        adel;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] A0 = 32'h1111_0000, A1 = 32'h1111_0001, A2 = 32'h1111_0002;
    localparam logic [31:0] A3 = 32'h1111_0003, B0 = 32'h2222_0000, B1 = 32'h2222_0001;
    localparam logic [31:0] C0 = 32'h3333_0000, C1 = 32'h3333_0001, C2 = 32'h3333_0002;
    localparam logic [31:0] C9 = 32'h3333_0009, D0 = 32'h4444_0000, E0 = 32'h5555_0000;
    localparam logic [31:0] DD = 32'hDEAD_BEEF, Z = 32'h0000_0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                              input logic v, input logic adel);
        check({tag, " InstrF"}, InstrF, instr);
        check({tag, " PCplus4F"}, PCplus4F, pc4);
        check({tag, " fetch_validF"}, {31'd0, fetch_validF}, {31'd0, v});
        check({tag, " adelF"}, {31'd0, adelF}, {31'd0, adel});
        check({tag, " fetch_stallF"}, {31'd0, fetch_stallF}, {31'd0, ~v});
    endtask

    task automatic drive_idle();
        enable      = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = Z;
        eretD       = 1'b0;
        epc         = Z;
        exc_en      = 1'b0;
        imem_ready  = 1'b0;
        imem_rdata  = Z;
    endtask

    initial begin
        // en rdy rdata ren rpc er epc ex | req addr valid instr pc4 adel
        // zero-wait streaming from reset
        vecs.push_back('{1'b1,1'b1,A0,1'b0,Z,1'b0,Z,1'b0, 1'b1,32'h3000,1'b0,Z ,Z      ,1'b0});
        vecs.push_back('{1'b1,1'b1,A1,1'b0,Z,1'b0,Z,1'b0, 1'b1,32'h3004,1'b1,A0,32'h3004,1'b0});
        vecs.push_back('{1'b1,1'b1,A2,1'b0,Z,1'b0,Z,1'b0, 1'b1,32'h3008,1'b1,A1,32'h3008,1'b0});
        // stall three cycles holding the instruction from 0x3008
        vecs.push_back('{1'b0,1'b0,Z ,1'b0,Z,1'b0,Z,1'b0, 1'b0,32'h300C,1'b1,A2,32'h300C,1'b0});
        vecs.push_back('{1'b0,1'b0,Z ,1'b0,Z,1'b0,Z,1'b0, 1'b0,32'h300C,1'b1,A2,32'h300C,1'b0});
        vecs.push_back('{1'b0,1'b0,Z ,1'b0,Z,1'b0,Z,1'b0, 1'b0,32'h300C,1'b1,A2,32'h300C,1'b0});
        // resume: fetch of 0x300C with two wait cycles
        vecs.push_back('{1'b1,1'b0,Z ,1'b0,Z,1'b0,Z,1'b0, 1'b1,32'h300C,1'b1,A2,32'h300C,1'b0});
        vecs.push_back('{1'b1,1'b0,Z ,1'b0,Z,1'b0,Z,1'b0, 1'b1,32'h300C,1'b0,A2,32'h300C,1'b0});
        vecs.push_back('{1'b1,1'b1,A3,1'b0,Z,1'b0,Z,1'b0, 1'b1,32'h300C,1'b0,A2,32'h300C,1'b0});
        // redirect to 0x3100 while 0x3010 is waiting -> discard
        vecs.push_back('{1'b1,1'b0,Z ,1'b0,Z,1'b0,Z,1'b0, 1'b1,32'h3010,1'b1,A3,32'h3010,1'b0});
        vecs.push_back('{1'b1,1'b0,Z ,1'b1,32'h3100,1'b0,Z,1'b0, 1'b1,32'h3010,1'b0,A3,32'h3010,1'b0});
        vecs.push_back('{1'b1,1'b0,Z ,1'b0,Z,1'b0,Z,1'b0, 1'b1,32'h3010,1'b0,A3,32'h3010,1'b0});
        vecs.push_back('{1'b1,1'b1,DD,1'b0,Z,1'b0,Z,1'b0, 1'b1,32'h3010,1'b0,A3,32'h3010,1'b0});
        vecs.push_back('{1'b1,1'b1,B0,1'b0,Z,1'b0,Z,1'b0, 1'b1,32'h3100,1'b0,A3,32'h3010,1'b0});
        // all three redirect sources at once, then eret alone
        vecs.push_back('{1'b1,1'b1,B1,1'b1,32'h3200,1'b1,32'h3050,1'b1, 1'b1,32'h3104,1'b1,B0,32'h3104,1'b0});
        vecs.push_back('{1'b1,1'b1,C0,1'b0,Z,1'b1,32'h3050,1'b0, 1'b1,32'h4180,1'b0,B0,32'h3104,1'b0});
        vecs.push_back('{1'b1,1'b1,C1,1'b0,Z,1'b0,Z,1'b0, 1'b1,32'h3050,1'b0,B0,32'h3104,1'b0});
        // misaligned target 0x3102
        vecs.push_back('{1'b1,1'b1,C9,1'b1,32'h3102,1'b0,Z,1'b0, 1'b1,32'h3054,1'b1,C1,32'h3054,1'b0});
        vecs.push_back('{1'b1,1'b1,C2,1'b0,Z,1'b0,Z,1'b0, 1'b1,32'h3100,1'b0,C1,32'h3054,1'b0});
        vecs.push_back('{1'b0,1'b0,Z ,1'b0,Z,1'b0,Z,1'b0, 1'b0,32'h3104,1'b1,Z ,32'h3106,1'b1});
        // discard with target overwritten, then wrap of pc+4
        vecs.push_back('{1'b1,1'b0,Z ,1'b1,32'h3300,1'b0,Z,1'b0, 1'b1,32'h3104,1'b1,Z,32'h3106,1'b1});
        vecs.push_back('{1'b1,1'b0,Z ,1'b1,32'hFFFF_FFFC,1'b0,Z,1'b0, 1'b1,32'h3104,1'b0,Z,32'h3106,1'b1});
        vecs.push_back('{1'b1,1'b1,DD,1'b0,Z,1'b0,Z,1'b0, 1'b1,32'h3104,1'b0,Z ,32'h3106,1'b1});
        vecs.push_back('{1'b1,1'b1,D0,1'b0,Z,1'b0,Z,1'b0, 1'b1,32'hFFFF_FFFC,1'b0,Z,32'h3106,1'b1});
        vecs.push_back('{1'b1,1'b0,Z ,1'b0,Z,1'b0,Z,1'b0, 1'b1,32'h0000,1'b1,D0,Z,1'b0});
        // discard where a new redirect arrives on the ready cycle
        vecs.push_back('{1'b1,1'b0,Z ,1'b1,32'h3400,1'b0,Z,1'b0, 1'b1,32'h0000,1'b0,D0,Z,1'b0});
        vecs.push_back('{1'b1,1'b1,DD,1'b1,32'h3500,1'b0,Z,1'b0, 1'b1,32'h0000,1'b0,D0,Z,1'b0});
        vecs.push_back('{1'b1,1'b0,Z ,1'b0,Z,1'b0,Z,1'b0, 1'b1,32'h3500,1'b0,D0,Z,1'b0});

        drive_idle();
        reset = 1'b1;
        #1;
        check("reset imem_req", {31'd0, imem_req}, 32'd0);
        check_regs("reset", Z, Z, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag         = $sformatf("row%0d", i);
            enable      = vecs[i].en;
            imem_ready  = vecs[i].rdy;
            imem_rdata  = vecs[i].rd;
            redirect_en = vecs[i].ren;
            redirect_pc = vecs[i].rpc;
            eretD       = vecs[i].er;
            epc         = vecs[i].ep;
            exc_en      = vecs[i].ex;
            #1;
            check({tag, " imem_req"}, {31'd0, imem_req}, {31'd0, vecs[i].req});
            check({tag, " imem_addr"}, imem_addr, vecs[i].addr);
            check_regs(tag, vecs[i].instr, vecs[i].pc4, vecs[i].v, vecs[i].adel);
            @(posedge clk);
            #1;
        end

        // asynchronous reset in the middle of a waiting fetch of 0x3500
        drive_idle();
        #3;
        reset = 1'b1;
        #1;
        check("async rst imem_req", {31'd0, imem_req}, 32'd0);
        check_regs("async rst", Z, Z, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post rst req", {31'd0, imem_req}, 32'd1);
        check("post rst addr", imem_addr, 32'h3000);
        // two wait cycles on the first fetch after reset
        @(posedge clk);
        #1;
        check("wait1 addr", imem_addr, 32'h3000);
        check("wait1 valid", {31'd0, fetch_validF}, 32'd0);
        @(posedge clk);
        #1;
        check("wait2 addr", imem_addr, 32'h3000);
        check("wait2 valid", {31'd0, fetch_validF}, 32'd0);
        imem_ready = 1'b1;
        imem_rdata = E0;
        @(posedge clk);
        #1;
        imem_ready = 1'b0;
        imem_rdata = Z;
        check_regs("ready", E0, 32'h3004, 1'b1, 1'b0);
        check("ready next addr", imem_addr, 32'h3004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Fetch-stage producer that drives the F-side of the fetch/decode pipeline register: holds the PC, issues word fetches to instruction memory over a req/ready handshake, and presents InstrF/PCplus4F with a valid flag to the F/D register. It absorbs downstream stalls (enable low) and redirects from branch/jump, eret and exceptions. It discards in-flight fetches made stale by a redirect.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded on reset
EXC_VECTOR, 32'h0000_4180, exception handler entry

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
enable  in  1  F/D register accepts this cycle (low = stall)
redirect_en  in  1  branch/jump taken, from D stage
redirect_pc  in  32  branch/jump target
eretD  in  1  eret in D stage
epc  in  32  return address for eret
exc_en  in  1  exception taken
imem_req  out  1  fetch request
imem_addr  out  32  word address, {pc[31:2],2'b00}
imem_ready  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  instruction word
InstrF  out  32  fetched instruction (registered)
PCplus4F  out  32  address of InstrF + 4 (registered)
fetch_validF  out  1  InstrF/PCplus4F hold a live instruction
adelF  out  1  InstrF fetched from misaligned PC (InstrF forced 0)
fetch_stallF  out  1  ~fetch_validF, to hazard unit

Behaviour:
- Reset (async): pc=RESET_PC, state=REQ, InstrF=0, PCplus4F=0, fetch_validF=0, adelF=0, discard target=0.
- States: REQ (issuing/awaiting fetch of pc), DISCARD (stale request outstanding, new target latched).
- Consume: output buffer drained when fetch_validF && enable.
- imem_req = (REQ && (!fetch_validF || enable)) || DISCARD. It is combinational on enable. imem_addr must stay stable while imem_req=1 and imem_ready=0.
- Redirect select: exc_en > eretD > redirect_en. Target is EXC_VECTOR, epc or redirect_pc respectively. redir = any of the three.
- REQ, imem_req && imem_ready, no redir: load InstrF=imem_rdata, PCplus4F=pc+4, adelF=(pc[1:0]!=0), with InstrF=0 when adelF. Set fetch_validF=1 and pc<=pc+4. Stay in REQ. Zero-wait memory gives 1 instr/cycle.
- REQ, redir && (ready or no request outstanding): pc<=target, fetch_validF<=0, stay in REQ. The returning data is dropped.
- REQ, redir while imem_req=1 && !imem_ready: latch target, fetch_validF<=0, go to DISCARD. pc is held so the address stays stable.
- DISCARD: keep imem_req=1 with old address. A further redir overwrites the latched target (same priority). On imem_ready, drop data, pc<=latched target (or new redir target if asserted that cycle), go to REQ.
- Stall: fetch_validF && !enable means InstrF/PCplus4F/adelF are held and no new request is issued. A request already outstanding when the stall begins is impossible by construction, because imem_req drops the same cycle.
- Consume without refill (enable, buffer valid, no ready): fetch_validF<=0.
- Redirect has priority over consume; a consumed-and-redirected cycle leaves fetch_validF=0.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). No overflow flag.
- Reset asserted mid-handshake aborts immediately. Memory must tolerate a dropped request.

Test Plan:
- Reset then zero-wait memory, enable=1: imem_addr 0x3000,0x3004,0x3008 on consecutive cycles; PCplus4F 0x3004,0x3008,0x300C one cycle later; fetch_validF=1 from cycle 2.
- Memory with 2 wait cycles: fetch_validF=0 until the ready cycle, then InstrF=rdata and PCplus4F=0x3004. imem_addr stable across waits.
- Valid instr at pc 0x3008, enable=0 for 3 cycles: InstrF/PCplus4F=0x300C held, imem_req=0. On enable=1, next fetch at 0x300C.
- redirect_en with redirect_pc=0x3100 during a waiting fetch of 0x3010: enter DISCARD, imem_addr stays 0x3010 until ready, data dropped, next imem_addr=0x3100, no InstrF from 0x3010 ever valid.
- exc_en, eretD(epc=0x3050) and redirect_en in the same cycle: next fetch address 0x4180. Next cycle eretD alone: next fetch 0x3050.
- redirect_pc=0x3102: adelF=1, InstrF=0, PCplus4F=0x3106, fetch_validF=1. Async reset mid-wait: outputs 0 and imem_req=0 immediately, next fetch 0x3000.
